// File: rtl/adc_bitstream_decim_if.sv
// Sample-word handshake between the decimator and the metering/DSP consumer.
interface adc_bitstream_decim_if #(
  parameter int CHANNELS = 6,
  parameter int CNT_W    = 9
);
  logic [CHANNELS*CNT_W-1:0] sample;
  logic                      sample_valid;
  logic                      sample_ready;

  modport master (output sample, sample_valid, input sample_ready);
  modport slave  (input sample, sample_valid, output sample_ready);
endinterface

// File: rtl/adc_bitstream_decim.sv
// Sigma-delta bitstream capture: input synchroniser, per-channel sinc1 decimator,
// stuck-modulator detection and a valid/ready sample word with overrun flag.
module adc_decim_lane #(
  parameter int CNT_W     = 9,
  parameter int STUCK_LIM = 1024,
  parameter int RUN_W     = $clog2(STUCK_LIM+1)
) (
  input  logic             mclkin,
  input  logic             rst_n,
  input  logic             i_mdat,
  input  logic             i_run,
  input  logic             i_done,
  input  logic             i_clr_flags,
  output logic [CNT_W-1:0] o_final,
  output logic             o_stuck
);
  logic [CNT_W-1:0] r_acc;
  logic [RUN_W-1:0] r_run_cnt;
  logic [RUN_W-1:0] w_run_nxt;
  logic             r_prev;
  logic             r_stuck;

  // The closing sample of a frame is folded in combinationally, so the full
  // DECIM-sample count is available on the frame-complete edge.
  assign o_final = r_acc + CNT_W'(i_mdat);
  assign o_stuck = r_stuck;

  always_comb begin
    w_run_nxt = '0;
    if (i_mdat == r_prev)
      w_run_nxt = (r_run_cnt == RUN_W'(STUCK_LIM)) ? r_run_cnt : r_run_cnt + 1'b1;
  end

  always_ff @(posedge mclkin or negedge rst_n) begin
    if (!rst_n) begin
      r_acc     <= '0;
      r_run_cnt <= '0;
      r_prev    <= 1'b0;
      r_stuck   <= 1'b0;
    end else begin
      if (!i_run || i_done) r_acc <= '0;
      else                  r_acc <= o_final;
      r_prev    <= i_mdat;
      r_run_cnt <= w_run_nxt;
      if (w_run_nxt == RUN_W'(STUCK_LIM)) r_stuck <= 1'b1;
      else if (i_clr_flags)               r_stuck <= 1'b0;
    end
  end
endmodule

module adc_bitstream_decim #(
  parameter int CHANNELS    = 6,
  parameter int DECIM       = 256,
  parameter int CNT_W       = $clog2(DECIM+1),
  parameter int SYNC_STAGES = 2,
  parameter int STUCK_LIM   = 1024
) (
  input  logic                  mclkin,
  input  logic                  rst_n,
  input  logic                  i_en,
  input  logic [CHANNELS-1:0]   i_data_in,
  output logic [CHANNELS-1:0]   o_mdat,
  output logic                  o_overrun,
  output logic [CHANNELS-1:0]   o_stuck,
  input  logic                  i_clr_flags,
  adc_bitstream_decim_if.master s_if
);
  localparam int PH_W = $clog2(DECIM);

  typedef enum logic {IDLE, RUN} state_t;

  state_t                               r_state, w_state_nxt;
  logic [SYNC_STAGES-1:0][CHANNELS-1:0] r_sync;
  logic [PH_W-1:0]                      r_phase;
  logic [CHANNELS-1:0][CNT_W-1:0]       w_final;
  logic [CHANNELS-1:0][CNT_W-1:0]       r_sample;
  logic                                 r_valid;
  logic                                 r_overrun;
  logic                                 w_run;
  logic                                 w_done;
  logic                                 w_load;

  always_ff @(posedge mclkin or negedge rst_n) begin
    if (!rst_n) begin
      r_sync <= '0;
    end else begin
      r_sync[0] <= i_data_in;
      for (int s = 1; s < SYNC_STAGES; s++) r_sync[s] <= r_sync[s-1];
    end
  end

  assign o_mdat = r_sync[SYNC_STAGES-1];

  always_ff @(posedge mclkin or negedge rst_n) begin
    if (!rst_n) r_state <= IDLE;
    else        r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      IDLE:    if (i_en)  w_state_nxt = RUN;
      RUN:     if (!i_en) w_state_nxt = IDLE;
      default: w_state_nxt = IDLE;
    endcase
  end

  // Dropping en in RUN discards the partial frame: w_run low clears acc/phase.
  always_comb begin
    w_run  = (r_state == RUN) && i_en;
    w_done = w_run && (r_phase == PH_W'(DECIM-1));
  end

  always_ff @(posedge mclkin or negedge rst_n) begin
    if (!rst_n)                r_phase <= '0;
    else if (!w_run || w_done) r_phase <= '0;
    else                       r_phase <= r_phase + 1'b1;
  end

  for (genvar c = 0; c < CHANNELS; c++) begin : g_lane
    adc_decim_lane #(.CNT_W(CNT_W), .STUCK_LIM(STUCK_LIM)) u_lane (
      .mclkin      (mclkin),
      .rst_n       (rst_n),
      .i_mdat      (o_mdat[c]),
      .i_run       (w_run),
      .i_done      (w_done),
      .i_clr_flags (i_clr_flags),
      .o_final     (w_final[c]),
      .o_stuck     (o_stuck[c])
    );
  end

  // A finished frame loads only if the output slot is empty or draining now.
  assign w_load = w_done && (!r_valid || s_if.sample_ready);

  always_ff @(posedge mclkin or negedge rst_n) begin
    if (!rst_n) begin
      r_sample  <= '0;
      r_valid   <= 1'b0;
      r_overrun <= 1'b0;
    end else begin
      if (w_load) begin
        r_sample <= w_final;
        r_valid  <= 1'b1;
      end else if (r_valid && s_if.sample_ready) begin
        r_valid  <= 1'b0;
      end
      if (w_done && !w_load) r_overrun <= 1'b1;
      else if (i_clr_flags)  r_overrun <= 1'b0;
    end
  end

  assign s_if.sample       = r_sample;
  assign s_if.sample_valid = r_valid;
  assign o_overrun         = r_overrun;
endmodule

// File: tb/tb_adc_bitstream_decim.sv
// Randomised bench for adc_bitstream_decim against a frame-level reference model.
module tb_adc_bitstream_decim;
  localparam int CH    = 6;
  localparam int DECIM = 16;
  localparam int CW    = 5;
  localparam int SYNC  = 2;
  localparam int LIM   = 32;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          en = 1'b0;
  logic [CH-1:0] data_in = '0;
  logic [CH-1:0] mdat;
  logic          overrun;
  logic [CH-1:0] stuck;
  logic          clr = 1'b0;

  adc_bitstream_decim_if #(.CHANNELS(CH), .CNT_W(CW)) bus ();

  adc_bitstream_decim #(.CHANNELS(CH), .DECIM(DECIM), .CNT_W(CW),
                        .SYNC_STAGES(SYNC), .STUCK_LIM(LIM)) dut (
    .mclkin      (clk),
    .rst_n       (rst_n),
    .i_en        (en),
    .i_data_in   (data_in),
    .o_mdat      (mdat),
    .o_overrun   (overrun),
    .o_stuck     (stuck),
    .i_clr_flags (clr),
    .s_if        (bus.master)
  );

  always #5 clk = ~clk;

  int n_chk = 0;
  int n_fail = 0;
  int cyc = 0;

  // Reference model state
  logic [CH-1:0]    sq[$];
  logic [CH-1:0]    frame[$];
  bit               m_running;
  logic [CH*CW-1:0] m_sample;
  bit               m_valid;
  bit               m_ovr;
  logic [CH-1:0]    m_stuck;
  logic [CH-1:0]    m_prev;
  int               streak[CH];

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  function automatic logic [CH-1:0] m_mdat();
    return (sq.size() == SYNC) ? sq[0] : '0;
  endfunction

  task automatic model_reset();
    sq.delete();
    frame.delete();
    m_running = 0;
    m_sample  = '0;
    m_valid   = 0;
    m_ovr     = 0;
    m_stuck   = '0;
    m_prev    = '0;
    for (int c = 0; c < CH; c++) streak[c] = 0;
  endtask

  // Applies one rising edge using the input values present before the edge.
  task automatic model_edge();
    logic [CH-1:0] cur;
    bit done, ovr_set;
    int n;
    if (!rst_n) begin
      model_reset();
      return;
    end
    cur = m_mdat();
    for (int c = 0; c < CH; c++) begin
      streak[c] = (cur[c] == m_prev[c]) ? streak[c] + 1 : 0;
      if (streak[c] >= LIM) m_stuck[c] = 1'b1;
      else if (clr)         m_stuck[c] = 1'b0;
    end
    m_prev = cur;
    done = 0;
    if (!m_running) m_running = en;
    else if (!en) begin
      m_running = 0;
      frame.delete();
    end else begin
      frame.push_back(cur);
      if (frame.size() == DECIM) done = 1;
    end
    ovr_set = 0;
    if (done) begin
      if (!m_valid || bus.sample_ready) begin
        for (int c = 0; c < CH; c++) begin
          n = 0;
          foreach (frame[i]) n += int'(frame[i][c]);
          m_sample[c*CW +: CW] = CW'(n);
        end
        m_valid = 1;
      end else ovr_set = 1;
      frame.delete();
    end else if (m_valid && bus.sample_ready) m_valid = 0;
    if (ovr_set)  m_ovr = 1;
    else if (clr) m_ovr = 0;
    sq.push_back(data_in);
    if (sq.size() > SYNC) void'(sq.pop_front());
  endtask

  task automatic check_all();
    chk("mdat", 64'(mdat), 64'(m_mdat()));
    chk("valid", 64'(bus.sample_valid), 64'(m_valid));
    chk("sample", 64'(bus.sample), 64'(m_sample));
    chk("overrun", 64'(overrun), 64'(m_ovr));
    chk("stuck", 64'(stuck), 64'(m_stuck));
    if (bus.sample_valid) begin
      chk("cnt_ch0_ones", 64'(bus.sample[0*CW +: CW]), 64'(DECIM));
      chk("cnt_ch1_toggle", 64'(bus.sample[1*CW +: CW]), 64'(DECIM/2));
      chk("cnt_ch2_zero", 64'(bus.sample[2*CW +: CW]), 64'd0);
    end
  endtask

  task automatic step();
    @(posedge clk);
    model_edge();
    #1;
    check_all();
  endtask

  // ch0=1, ch1 toggles, ch2=0, ch3=1, ch4 toggles every 20 cycles, ch5 random.
  task automatic drive_pattern();
    cyc++;
    data_in = {1'($urandom), 1'((cyc / 20) % 2), 1'b1, 1'b0, 1'(cyc % 2), 1'b1};
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) begin
      step();
      drive_pattern();
    end
  endtask

  initial begin
    bit hit;
    bus.sample_ready = 1'b0;
    model_reset();
    data_in = 6'b101101;
    #12;
    check_all();
    chk("rst_mdat", 64'(mdat), 64'd0);
    step();
    chk("rst_held_valid", 64'(bus.sample_valid), 64'd0);
    rst_n = 1'b1;
    step();
    chk("sync_lat1", 64'(mdat), 64'd0);
    step();
    chk("sync_lat2", 64'(mdat), 64'b101101);
    chk("sync_ovr", 64'(overrun), 64'd0);

    drive_pattern();
    run(3);
    en = 1'b1;
    bus.sample_ready = 1'b1;
    run(40);

    bus.sample_ready = 1'b0;
    run(40);
    chk("bp_overrun", 64'(overrun), 64'd1);
    bus.sample_ready = 1'b1;
    run(2);
    clr = 1'b1;
    run(1);
    clr = 1'b0;
    chk("clr_overrun", 64'(overrun), 64'd0);
    chk("stuck3_setwins", 64'(stuck[3]), 64'd1);
    chk("stuck4_toggling", 64'(stuck[4]), 64'd0);

    // Abort a frame part-way and restart it.
    run(5);
    en = 1'b0;
    run(3);
    en = 1'b1;
    run(40);

    for (int i = 0; i < 300; i++) begin
      en = ($urandom_range(0, 99) < 95);
      bus.sample_ready = 1'($urandom);
      clr = ($urandom_range(0, 99) < 3);
      run(1);
    end
    clr = 1'b0;
    en = 1'b1;

    // Asynchronous reset mid-frame with a word pending.
    bus.sample_ready = 1'b0;
    hit = 0;
    for (int i = 0; i < 200 && !hit; i++) begin
      run(1);
      hit = m_valid && (frame.size() == 9);
    end
    chk("reach_mid_frame", 64'(hit), 64'd1);
    #2;
    rst_n = 1'b0;
    #1;
    model_reset();
    check_all();
    chk("async_valid", 64'(bus.sample_valid), 64'd0);
    chk("async_sample", 64'(bus.sample), 64'd0);
    run(1);
    rst_n = 1'b1;
    en = 1'b0;
    bus.sample_ready = 1'b1;
    run(3);
    en = 1'b1;
    run(40);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
